// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, slot record and FSM encoding for pipe_hazard_ctrl.
// Optional WB-slot forwarding is enabled with the WB_FORWARD_EN macro.
package pipe_hazard_ctrl_pkg;

   localparam int SLOT_AW     = 5;
   localparam int STALL_BUS_W = 6;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam logic [5:0] STALL_NONE    = 6'b000000;
   localparam logic [5:0] STALL_LOADUSE = 6'b000111;
   localparam logic [5:0] STALL_DIV     = 6'b001111;

   localparam int STB_ID  = 2;
   localparam int STB_EX  = 3;
   localparam int STB_MEM = 4;
   localparam int STB_WB  = 5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   typedef struct packed {
      logic               valid;
      logic               we;
      logic [SLOT_AW-1:0] waddr;
      logic               is_load;
      logic               is_div;
   } slot_t;

   // hit[0]=EX, hit[1]=MEM, hit[2]=WB; newest writer wins
   function automatic logic [1:0] fwd_pick(input logic [2:0] hit,
                                           input logic       wb_en);
      logic [1:0] sel;
      sel = FWD_RF;
      if (hit[0])
         sel = FWD_EX;
      else if (hit[1])
         sel = FWD_MEM;
      else if (hit[2] && wb_en)
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// hazard_slot_match: does one tracked writer slot supply one ID source?
// Register 0 never matches.
module hazard_slot_match
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = SLOT_AW
) (
   input  logic              slot_valid,
   input  logic              slot_we,
   input  logic [REG_AW-1:0] slot_waddr,
   input  logic [REG_AW-1:0] src,
   input  logic              src_re,
   input  logic              id_valid,
   output logic              match
);

   assign match = slot_valid && slot_we
                && (slot_waddr != '0)
                && (slot_waddr == src)
                && src_re && id_valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: EX/MEM/WB writer tracking, forward selects, load-use
// and divider stalls. WB_FORWARD_EN enables forwarding from the WB slot.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW  = SLOT_AW,
   parameter int STALL_W = STALL_BUS_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic               id_rs_re,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic               id_rt_re,
   input  logic               id_we,
   input  logic [REG_AW-1:0]  id_waddr,
   input  logic               id_is_load,
   input  logic               id_is_div,
   input  logic               div_done,
   output logic [STALL_W-1:0] stall,
   output logic [1:0]         fwd_rs_sel,
   output logic [1:0]         fwd_rt_sel,
   output logic               div_start,
   output logic               div_abort
);

`ifdef WB_FORWARD_EN
   localparam logic WB_EN = 1'b1;
`else
   localparam logic WB_EN = 1'b0;
`endif

   slot_t      ex_q, ex_d;
   slot_t      mem_q, mem_d;
   slot_t      wb_q, wb_d;
   slot_t      id_slot;
   slot_t      slot_arr [3];
   logic [0:0] state_q, state_d;
   logic [2:0] rs_hit, rt_hit;
   logic       load_use, div_go, div_busy;
   logic [STALL_W-1:0] stall_c;
   logic       unused_slot_bits;

   assign slot_arr[0] = ex_q;
   assign slot_arr[1] = mem_q;
   assign slot_arr[2] = wb_q;

   for (genvar i = 0; i < 3; i++) begin : g_match
      hazard_slot_match #(.REG_AW(REG_AW)) u_rs (
         .slot_valid (slot_arr[i].valid),
         .slot_we    (slot_arr[i].we),
         .slot_waddr (slot_arr[i].waddr),
         .src        (id_rs),
         .src_re     (id_rs_re),
         .id_valid   (id_valid),
         .match      (rs_hit[i])
      );
      hazard_slot_match #(.REG_AW(REG_AW)) u_rt (
         .slot_valid (slot_arr[i].valid),
         .slot_we    (slot_arr[i].we),
         .slot_waddr (slot_arr[i].waddr),
         .src        (id_rt),
         .src_re     (id_rt_re),
         .id_valid   (id_valid),
         .match      (rt_hit[i])
      );
   end

   assign unused_slot_bits = &{mem_q.is_load, mem_q.is_div,
                               wb_q.is_load, wb_q.is_div};

   assign fwd_rs_sel = fwd_pick(rs_hit, WB_EN);
   assign fwd_rt_sel = fwd_pick(rt_hit, WB_EN);

   assign id_slot = '{valid:   id_valid,
                      we:      id_we,
                      waddr:   id_waddr,
                      is_load: id_is_load,
                      is_div:  id_is_div};

   always_comb begin
      load_use = ex_q.is_load && (rs_hit[0] || rt_hit[0]);
      // the div is held in EX from its start cycle until div_done
      div_go   = !flush && (state_q == ST_IDLE)
               && ex_q.valid && ex_q.is_div;
      div_busy = !flush && (state_q == ST_BUSY) && !div_done;

      stall_c = STALL_NONE;
      if (div_go || div_busy)
         stall_c = STALL_DIV;
      else if (!flush && load_use)
         stall_c = STALL_LOADUSE;

      div_start = div_go;
      div_abort = flush && (state_q == ST_BUSY);

      state_d = state_q;
      if (flush)
         state_d = ST_IDLE;
      else if (div_go)
         state_d = ST_BUSY;
      else if ((state_q == ST_BUSY) && div_done)
         state_d = ST_IDLE;

      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!stall_c[STB_EX])
         ex_d = stall_c[STB_ID] ? '0 : id_slot;
      if (!stall_c[STB_MEM])
         mem_d = stall_c[STB_EX] ? '0 : ex_q;
      if (!stall_c[STB_WB])
         wb_d = stall_c[STB_MEM] ? '0 : mem_q;
      if (flush) begin
         ex_d  = '0;
         mem_d = '0;
         wb_d  = '0;
      end
   end

   assign stall = stall_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         state_q <= ST_IDLE;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a
// stage-list reference model of the pipeline.
module tb_pipe_hazard_ctrl;

`ifdef WB_FORWARD_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   typedef struct packed {
      bit     v;
      bit     we;
      bit [4:0] wa;
      bit     ld;
      bit     dv;
   } ins_t;

   logic       clk = 1'b0;
   logic       rst, flush, id_valid, id_rs_re, id_rt_re;
   logic       id_we, id_is_load, id_is_div, div_done;
   logic [4:0] id_rs, id_rt, id_waddr;
   logic [5:0] stall;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic       div_start, div_abort;

   int checks = 0;
   int errors = 0;

   ins_t pipe [3];
   bit   running;
   bit   model_ok;

   logic [5:0] obs_stall;
   logic [1:0] obs_rs, obs_rt;
   logic       obs_start, obs_abort;

   pipe_hazard_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rs_re   (id_rs_re),
      .id_rt      (id_rt),
      .id_rt_re   (id_rt_re),
      .id_we      (id_we),
      .id_waddr   (id_waddr),
      .id_is_load (id_is_load),
      .id_is_div  (id_is_div),
      .div_done   (div_done),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .div_start  (div_start),
      .div_abort  (div_abort)
   );

   always #5 clk = ~clk;

   function automatic bit hit(int k, bit [4:0] src, bit re, bit iv);
      return iv && re && src != 0 && pipe[k].v
          && pipe[k].we && pipe[k].wa == src;
   endfunction

   function automatic logic [1:0] exp_fwd(bit [4:0] src, bit re, bit iv);
      for (int k = 0; k < 3; k++)
         if (hit(k, src, re, iv))
            return (k == 2) ? (WB_EN ? 2'd3 : 2'd0) : 2'(k + 1);
      return 2'd0;
   endfunction

   task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(bit f, bit r, bit iv,
                        bit [4:0] rs, bit rsre, bit [4:0] rt, bit rtre,
                        bit we, bit [4:0] wa, bit ld, bit dv, bit dd);
      bit   lu, rs_lu, rt_lu, dix, start, dstall;
      logic [5:0] es;
      ins_t idi, nx [3];
      @(negedge clk);
      flush = f; rst = r; id_valid = iv;
      id_rs = rs; id_rs_re = rsre; id_rt = rt; id_rt_re = rtre;
      id_we = we; id_waddr = wa; id_is_load = ld; id_is_div = dv;
      div_done = dd;
      #2;
      obs_stall = stall; obs_rs = fwd_rs_sel; obs_rt = fwd_rt_sel;
      obs_start = div_start; obs_abort = div_abort;

      rs_lu  = pipe[0].ld && hit(0, rs, rsre, iv);
      rt_lu  = pipe[0].ld && hit(0, rt, rtre, iv);
      lu     = rs_lu || rt_lu;
      dix    = pipe[0].v && pipe[0].dv;
      start  = !f && !running && dix;
      dstall = !f && ((!running && dix) || (running && !dd));
      es     = f ? 6'h00 : dstall ? 6'h0F : lu ? 6'h07 : 6'h00;

      if (model_ok) begin
         chk("stall", 8'(stall), 8'(es));
         if (!(lu && rs_lu)) chk("fwd_rs", 8'(fwd_rs_sel), 8'(exp_fwd(rs, rsre, iv)));
         if (!(lu && rt_lu)) chk("fwd_rt", 8'(fwd_rt_sel), 8'(exp_fwd(rt, rtre, iv)));
         chk("div_start", 8'(div_start), 8'(start));
         chk("div_abort", 8'(div_abort), 8'(f && running));
      end

      idi = '{v: iv, we: we, wa: wa, ld: ld, dv: dv};
      if (es == 6'h0F)      nx = '{pipe[0], '0, pipe[1]};
      else if (es == 6'h07) nx = '{'0, pipe[0], pipe[1]};
      else                  nx = '{idi, pipe[0], pipe[1]};
      @(posedge clk);
      if (r || f) begin
         pipe = '{'0, '0, '0};
         running = 0;
      end else begin
         pipe = nx;
         if (start) running = 1;
         else if (running && dd) running = 0;
      end
      if (r) model_ok = 1;
   endtask

   task automatic nop();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd_rs(bit [4:0] rs, bit dd);
      cycle(0, 0, 1, rs, 1, 0, 0, 0, 0, 0, 0, dd);
   endtask

   task automatic wr(bit [4:0] wa, bit ld, bit dv);
      cycle(0, 0, 1, 0, 0, 0, 0, 1, wa, ld, dv, 0);
   endtask

   initial begin
      int nstall, nstart;
      model_ok = 0;
      running  = 0;
      pipe     = '{'0, '0, '0};
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      nop();
      chk("rst_stall", 8'(obs_stall), 8'h00);
      chk("rst_rs", 8'(obs_rs), 8'h0);
      chk("rst_start", 8'(obs_start), 8'h0);

      // ADDU $8 then read rs=$8
      wr(8, 0, 0);
      rd_rs(8, 0);
      chk("addu_ex", 8'(obs_rs), 8'h1);
      chk("addu_ex_stall", 8'(obs_stall), 8'h00);
      rd_rs(8, 0);
      chk("addu_mem", 8'(obs_rs), 8'h2);

      // LW $9 then read rt=$9
      nop(); nop(); nop();
      wr(9, 1, 0);
      cycle(0, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      chk("lu_stall", 8'(obs_stall), 8'h07);
      cycle(0, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      chk("lu_fwd", 8'(obs_rt), 8'h2);
      chk("lu_release", 8'(obs_stall), 8'h00);

      // DIV: 17 stalled cycles, then div_done releases
      nop(); nop(); nop();
      wr(10, 0, 1);
      nstall = 0;
      nstart = 0;
      for (int i = 0; i < 17; i++) begin
         nop();
         if (obs_stall == 6'h0F) nstall++;
         if (obs_start) nstart++;
      end
      chk("div_stall_cycles", 8'(nstall), 8'd17);
      chk("div_start_once", 8'(nstart), 8'd1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("div_done_stall", 8'(obs_stall), 8'h00);
      nop();
      chk("div_idle", 8'(obs_start), 8'h0);

      // newest writer wins; $0 never forwards
      nop(); nop(); nop();
      wr(3, 0, 0);
      wr(3, 0, 0);
      rd_rs(3, 0);
      chk("newest_wins", 8'(obs_rs), 8'h1);
      wr(0, 0, 0);
      rd_rs(0, 0);
      chk("r0_nofwd", 8'(obs_rs), 8'h0);

      // flush in the 5th BUSY cycle
      nop(); nop(); nop();
      wr(12, 0, 1);
      nop();
      chk("div2_start", 8'(obs_start), 8'h1);
      for (int i = 0; i < 4; i++) nop();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("abort", 8'(obs_abort), 8'h1);
      chk("abort_stall", 8'(obs_stall), 8'h00);
      rd_rs(12, 0);
      chk("flushed_rs", 8'(obs_rs), 8'h0);
      chk("flushed_start", 8'(obs_start), 8'h0);

      // WB-slot writer
      wr(4, 0, 0);
      nop(); nop();
      rd_rs(4, 0);
      chk("wb_fwd", 8'(obs_rs), WB_EN ? 8'h3 : 8'h0);

      // reset during a load-use stall
      nop(); nop(); nop();
      wr(5, 1, 0);
      cycle(0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_before_rst", 8'(obs_stall), 8'h07);
      rd_rs(5, 0);
      chk("rst_clears", 8'(obs_stall), 8'h00);
      chk("rst_clears_rs", 8'(obs_rs), 8'h0);

      for (int i = 0; i < 3000; i++) begin
         bit dd;
         dd = running ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 19) == 0);
         cycle($urandom_range(0, 39) == 0,
               $urandom_range(0, 199) == 0,
               $urandom_range(0, 9) != 0,
               5'($urandom_range(0, 4)), 1'($urandom),
               5'($urandom_range(0, 4)), 1'($urandom),
               $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 4)),
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 19) == 0,
               dd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
